tile_fb_writer: RTL

- Tile colour framebuffer with a command-driven writer, sitting directly upstream of the VGA pixel output.
- Stores one 3-bit colour per 8x8 tile, 80x60 tiles for 640x480. A host/CPU side writes tiles through a valid/ready command port.
- The display side presents the hpos/vpos/display_on signals from the vga timing block and receives registered RGB.
- Replaces a static, initial-block-loaded tile array with runtime-writable storage and a hardware clear engine.

---
 rtl/tile_fb_writer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/tile_fb_writer.sv
// Tile colour framebuffer with a command-driven writer, feeding the VGA pixel output.
//
// One 3-bit colour is stored per tile (COLS x ROWS tiles). The host writes tiles through a
// valid/ready command port. The display side reads the tile under (hpos, vpos) and returns a
// registered colour one clock later.
//
// Ports:
//   clk         pixel clock; all logic is on this clock
//   rst         synchronous, active-high reset
//   cmd_valid   command present
//   cmd_ready   command can be accepted this cycle (IDLE and not in reset)
//   cmd_op      0=WRITE, 1=SETPOS, 2=CLEAR, 3=NOP
//   cmd_x/y     tile column/row for SETPOS
//   cmd_color   colour for WRITE and CLEAR
//   cmd_err     one-cycle pulse after an out-of-range SETPOS is accepted
//   busy        high while the CLEAR engine runs
//   hpos/vpos   pixel coordinates from the timing block
//   display_on  active-video flag
//   vsync       vertical sync (used only with TILE_FB_CURSOR_BLINK_EN)
//   rgb         registered pixel colour
//
// Optional build macro TILE_FB_CURSOR_BLINK_EN: inverts the cursor tile on alternate groups of
// BLINK_FRAMES frames.
module tile_fb_writer #(
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 60,
    parameter int unsigned TILE_SHIFT   = 3,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [6:0] cmd_x,
    input  logic [5:0] cmd_y,
    input  logic [2:0] cmd_color,
    output logic       cmd_err,
    output logic       busy,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       display_on,
    input  logic       vsync,
    output logic [2:0] rgb
);

    localparam int unsigned Cells    = COLS * ROWS;
    localparam logic [12:0] LastAddr = 13'(Cells - 1);
    localparam logic [12:0] ColsA    = 13'(COLS);
    localparam logic [6:0]  ColsX    = 7'(COLS);
    localparam logic [5:0]  RowsY    = 6'(ROWS);
    localparam logic [6:0]  LastX    = 7'(COLS - 1);
    localparam logic [5:0]  LastY    = 6'(ROWS - 1);
    localparam logic [9:0]  ColsT    = 10'(COLS);
    localparam logic [9:0]  RowsT    = 10'(ROWS);

    localparam logic [1:0] OpWrite  = 2'd0;
    localparam logic [1:0] OpSetpos = 2'd1;
    localparam logic [1:0] OpClear  = 2'd2;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e      state_q, state_d;
    logic [6:0]  cur_x_q, cur_x_d;
    logic [5:0]  cur_y_q, cur_y_d;
    logic [12:0] clr_addr_q, clr_addr_d;
    logic [2:0]  clr_color_q, clr_color_d;
    logic        cmd_err_q, cmd_err_d;
    logic [2:0]  rgb_q, rgb_d;

    logic [2:0]  mem [Cells];
    logic        we;
    logic [12:0] waddr;
    logic [2:0]  wdata;
    logic        accept;
    logic [12:0] cur_addr;

    assign cmd_ready = (state_q == StIdle) && !rst;
    assign busy      = (state_q == StClear) && !rst;
    assign cmd_err   = cmd_err_q;
    assign rgb       = rgb_q;
    assign accept    = cmd_valid && cmd_ready;
    assign cur_addr  = 13'(cur_y_q) * ColsA + 13'(cur_x_q);

    always_comb begin
        state_d     = state_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        clr_addr_d  = clr_addr_q;
        clr_color_d = clr_color_q;
        cmd_err_d   = 1'b0;
        we          = 1'b0;
        waddr       = cur_addr;
        wdata       = cmd_color;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (cmd_op)
                        OpWrite: begin
                            we = 1'b1;
                            if (cur_x_q == LastX) begin
                                cur_x_d = '0;
                                cur_y_d = (cur_y_q == LastY) ? '0 : cur_y_q + 6'd1;
                            end else begin
                                cur_x_d = cur_x_q + 7'd1;
                            end
                        end
                        OpSetpos: begin
                            if (cmd_x < ColsX && cmd_y < RowsY) begin
                                cur_x_d = cmd_x;
                                cur_y_d = cmd_y;
                            end else begin
                                cmd_err_d = 1'b1;
                            end
                        end
                        OpClear: begin
                            state_d     = StClear;
                            clr_addr_d  = '0;
                            clr_color_d = cmd_color;
                        end
                        default: ;
                    endcase
                end
            end
            StClear: begin
                we    = 1'b1;
                waddr = clr_addr_q;
                wdata = clr_color_q;
                if (clr_addr_q == LastAddr) begin
                    state_d    = StIdle;
                    clr_addr_d = '0;
                    cur_x_d    = '0;
                    cur_y_d    = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 13'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
            cmd_err_q   <= 1'b0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            clr_addr_q  <= clr_addr_d;
            clr_color_q <= clr_color_d;
            cmd_err_q   <= cmd_err_d;
            rgb_q       <= rgb_d;
        end
    end

    // Storage is not reset; a write on a reset edge is dropped so an aborted CLEAR stops cleanly.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[waddr] <= wdata;
        end
    end

    // Display read path: the nonblocking write above gives read-before-write on the same cell.
    logic [9:0]  tx, ty;
    logic        in_view;
    logic [12:0] raddr;
    logic        blink_hit;

    assign tx      = hpos >> TILE_SHIFT;
    assign ty      = vpos >> TILE_SHIFT;
    assign in_view = display_on && (tx < ColsT) && (ty < RowsT);
    assign raddr   = 13'(ty) * ColsA + 13'(tx);

`ifdef TILE_FB_CURSOR_BLINK_EN
    localparam int unsigned FcW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic           vsync_q;
    logic [FcW-1:0] frame_q, frame_d;
    logic           blink_q, blink_d;

    always_comb begin
        frame_d = frame_q;
        blink_d = blink_q;
        if (vsync && !vsync_q) begin
            if (frame_q == FcW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                blink_d = !blink_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            frame_q <= '0;
            blink_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
            frame_q <= frame_d;
            blink_q <= blink_d;
        end
    end

    assign blink_hit = blink_q && (tx == 10'(cur_x_q)) && (ty == 10'(cur_y_q));
`else
    logic unused_vsync;
    localparam int unsigned unused_blink_frames = BLINK_FRAMES;
    assign unused_vsync = vsync;
    assign blink_hit    = 1'b0;
`endif

    always_comb begin
        rgb_d = '0;
        if (in_view) begin
            rgb_d = blink_hit ? ~mem[raddr] : mem[raddr];
        end
    end

endmodule
